// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter sharing one fifo write port among
// NREQ valid/ready/last producers. A grant covers one burst, bounded by
// MAX_BURST beats, and is revoked if the granted producer idles for IDLE_TO
// cycles. One IDLE cycle always separates consecutive bursts.
module fifo_wr_arb #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8,
    parameter int IDLE_TO   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    fifo_we,
    output logic [WIDTH-1:0]        fifo_din,
    input  logic                    fifo_full,
    input  logic                    fifo_p_full,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [7:0]              beat_cnt,
    output logic                    abort
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(IDLE_TO + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   g_idx;
    logic [IW-1:0]   sel;
    logic            found;
    logic [TW-1:0]   idle_cnt;
    logic            xfer;
    logic            end_burst;

    // Pick the first valid requester after the last one served, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(rr_ptr) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    // Fifo-side handshake for the granted requester; only fifo_full stalls a burst.
    always_comb begin
        xfer      = (state == BURST) && req_valid[g_idx] && !fifo_full;
        fifo_we   = xfer;
        fifo_din  = req_data[g_idx*WIDTH +: WIDTH];
        req_ready = ((state == BURST) && !fifo_full) ? grant : '0;
        end_burst = req_last[g_idx] || (beat_cnt == 8'(MAX_BURST - 1));
    end

    // Arbitration FSM with registered grant/busy/beat_cnt/abort and idle timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            abort    <= 1'b0;
            rr_ptr   <= IW'(NREQ - 1);
            g_idx    <= '0;
            idle_cnt <= '0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (found && !fifo_p_full) begin
                        state    <= BURST;
                        grant    <= NREQ'(1) << sel;
                        g_idx    <= sel;
                        rr_ptr   <= sel;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        if (end_burst) begin
                            state    <= IDLE;
                            grant    <= '0;
                            busy     <= 1'b0;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end else if (req_valid[g_idx]) begin
                        // valid but stalled by fifo_full: producer is not idle
                        idle_cnt <= '0;
                    end else if (!fifo_full) begin
                        if (idle_cnt == TW'(IDLE_TO - 1)) begin
                            state    <= IDLE;
                            grant    <= '0;
                            busy     <= 1'b0;
                            beat_cnt <= '0;
                            abort    <= 1'b1;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: cycle vectors for the single-requester and backpressure
// cases, then producer queues plus a write scoreboard for round-robin,
// MAX_BURST cut, idle timeout and asynchronous reset mid-burst.
module tb_fifo_wr_arb;

    localparam int WIDTH     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 8;
    localparam int IDLE_TO   = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_we;
    logic [WIDTH-1:0]      fifo_din;
    logic                  fifo_full;
    logic                  fifo_p_full;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [7:0]            beat_cnt;
    logic                  abort;

    fifo_wr_arb #(
        .WIDTH    (WIDTH),
        .NREQ     (NREQ),
        .MAX_BURST(MAX_BURST),
        .IDLE_TO  (IDLE_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_we    (fifo_we),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .fifo_p_full(fifo_p_full),
        .grant      (grant),
        .busy       (busy),
        .beat_cnt   (beat_cnt),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NREQ-1:0]       v;
        logic [NREQ*WIDTH-1:0] d;
        logic [NREQ-1:0]       l;
        logic                  full;
        logic                  pfull;
        logic [NREQ-1:0]       e_grant;
        logic                  e_busy;
        logic                  e_we;
        logic [7:0]            e_din;
        logic [7:0]            e_bcnt;
        logic [NREQ-1:0]       e_ready;
    } vec_t;

    vec_t vt [18];

    // producer queues: {last, data}
    logic [8:0]       pq [NREQ][$];
    logic [7:0]       exp_q[$];
    int               eg_q[$];
    int               eb_q[$];
    logic [NREQ-1:0]  fire;
    logic [NREQ-1:0]  prev_grant;
    int               burst_beats, gap, cyc, t_drop, t_abort, n_abort;
    bit               had_burst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++)
            if (g[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        fifo_full   = 1'b0;
        fifo_p_full = 1'b0;
        for (int i = 0; i < NREQ; i++) pq[i].delete();
        exp_q.delete();
        eg_q.delete();
        eb_q.delete();
        prev_grant  = '0;
        burst_beats = 0;
        gap         = 0;
        had_burst   = 1'b0;
        t_drop      = -1;
        t_abort     = -1;
        n_abort     = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_abort", abort, 0);
        chk("rst_fifo_we", fifo_we, 0);
        chk("rst_req_ready", req_ready, 0);
        rst = 1'b0;
    endtask

    // Drive producers from their queues, then sample and score the cycle.
    task automatic bfm_sample();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (pq[i].size() > 0) begin
                req_valid[i]               = 1'b1;
                req_data[i*WIDTH +: WIDTH] = pq[i][0][7:0];
                req_last[i]                = pq[i][0][8];
            end else begin
                req_valid[i]               = 1'b0;
                req_data[i*WIDTH +: WIDTH] = 8'hEE;
                req_last[i]                = 1'b0;
            end
        end
        fifo_full   = 1'b0;
        fifo_p_full = 1'b0;
        #1;
        cyc++;
        fire = req_valid & req_ready;
        chk("we_vs_handshake", fifo_we, |fire);
        chk("grant_onehot0", $onehot0(grant), 1);
        if (fifo_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got din %0h expected no write", fifo_din);
            end else begin
                chk("fifo_din", fifo_din, exp_q.pop_front());
            end
        end
        if (grant !== prev_grant) begin
            if (prev_grant != '0) begin
                if (eb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_burst: got %0d beats expected no burst", burst_beats);
                end else begin
                    chk("burst_beats", burst_beats, eb_q.pop_front());
                end
                had_burst = 1'b1;
                gap       = 1;
            end
            if (grant != '0) begin
                if (eg_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_grant: got grant %b expected none", grant);
                end else begin
                    chk("grant_order", oh_idx(grant), eg_q.pop_front());
                end
                if (had_burst) chk("idle_gap", gap, 1);
                burst_beats = 0;
            end
        end else if (grant == '0) begin
            gap++;
        end
        if (fifo_we) burst_beats++;
        if (t_drop < 0 && grant != '0 && (req_valid & grant) == '0) t_drop = cyc;
        if (abort) begin
            n_abort++;
            t_abort = cyc;
            chk("abort_grant", grant, 0);
        end
        prev_grant = grant;
    endtask

    task automatic bfm_commit();
        @(posedge clk);
        for (int i = 0; i < NREQ; i++)
            if (fire[i]) void'(pq[i].pop_front());
    endtask

    task automatic run_until_done(input string name, input int budget);
        int  n;
        bit  done;
        done = 1'b0;
        for (n = 0; n < budget && !done; n++) begin
            bfm_sample();
            bfm_commit();
            done = (exp_q.size() == 0);
            for (int i = 0; i < NREQ; i++)
                if (pq[i].size() != 0) done = 1'b0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_budget: got %0d writes pending expected 0 after %0d cycles", name, exp_q.size(), budget);
        end
        repeat (3) begin
            bfm_sample();
            bfm_commit();
        end
        chk({name, "_grants_left"}, eg_q.size(), 0);
        chk({name, "_bursts_left"}, eb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        bit hit;
        cyc = 0;

        //         v        d              l     f  p   grant  b  we din    bcnt  ready
        vt[0]  = '{4'b0001, 32'hBBBBBB10, 4'b0000, 0, 0, 4'b0000, 0, 0, 8'h00, 8'd0, 4'b0000};
        vt[1]  = '{4'b0001, 32'hBBBBBB10, 4'b0000, 0, 0, 4'b0001, 1, 1, 8'h10, 8'd0, 4'b0001};
        vt[2]  = '{4'b0001, 32'hBBBBBB11, 4'b0000, 0, 0, 4'b0001, 1, 1, 8'h11, 8'd1, 4'b0001};
        vt[3]  = '{4'b0001, 32'hBBBBBB12, 4'b0000, 0, 0, 4'b0001, 1, 1, 8'h12, 8'd2, 4'b0001};
        vt[4]  = '{4'b0001, 32'hBBBBBB13, 4'b0000, 0, 0, 4'b0001, 1, 1, 8'h13, 8'd3, 4'b0001};
        vt[5]  = '{4'b0001, 32'hBBBBBB14, 4'b0001, 0, 0, 4'b0001, 1, 1, 8'h14, 8'd4, 4'b0001};
        vt[6]  = '{4'b0000, 32'h00000000, 4'b0000, 0, 0, 4'b0000, 0, 0, 8'h00, 8'd0, 4'b0000};
        vt[7]  = '{4'b0010, 32'hAAAA20AA, 4'b0000, 0, 1, 4'b0000, 0, 0, 8'h00, 8'd0, 4'b0000};
        vt[8]  = '{4'b0010, 32'hAAAA20AA, 4'b0000, 0, 1, 4'b0000, 0, 0, 8'h00, 8'd0, 4'b0000};
        vt[9]  = '{4'b0010, 32'hAAAA20AA, 4'b0000, 0, 1, 4'b0000, 0, 0, 8'h00, 8'd0, 4'b0000};
        vt[10] = '{4'b0010, 32'hAAAA20AA, 4'b0000, 0, 0, 4'b0000, 0, 0, 8'h00, 8'd0, 4'b0000};
        vt[11] = '{4'b0010, 32'hAAAA20AA, 4'b0000, 0, 1, 4'b0010, 1, 1, 8'h20, 8'd0, 4'b0010};
        vt[12] = '{4'b0010, 32'hAAAA21AA, 4'b0000, 1, 1, 4'b0010, 1, 0, 8'h21, 8'd1, 4'b0000};
        vt[13] = '{4'b0010, 32'hAAAA21AA, 4'b0000, 1, 1, 4'b0010, 1, 0, 8'h21, 8'd1, 4'b0000};
        vt[14] = '{4'b0010, 32'hAAAA21AA, 4'b0000, 1, 1, 4'b0010, 1, 0, 8'h21, 8'd1, 4'b0000};
        vt[15] = '{4'b0010, 32'hAAAA21AA, 4'b0000, 0, 0, 4'b0010, 1, 1, 8'h21, 8'd1, 4'b0010};
        vt[16] = '{4'b0010, 32'hAAAA22AA, 4'b0010, 0, 0, 4'b0010, 1, 1, 8'h22, 8'd2, 4'b0010};
        vt[17] = '{4'b0000, 32'h00000000, 4'b0000, 0, 0, 4'b0000, 0, 0, 8'h00, 8'd0, 4'b0000};

        // single requester burst, p_full gating in IDLE, fifo_full stall mid-burst
        do_reset();
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            req_valid   = vt[k].v;
            req_data    = vt[k].d;
            req_last    = vt[k].l;
            fifo_full   = vt[k].full;
            fifo_p_full = vt[k].pfull;
            #1;
            chk($sformatf("vec%0d_grant", k), grant, vt[k].e_grant);
            chk($sformatf("vec%0d_busy", k), busy, vt[k].e_busy);
            chk($sformatf("vec%0d_we", k), fifo_we, vt[k].e_we);
            chk($sformatf("vec%0d_beat_cnt", k), beat_cnt, vt[k].e_bcnt);
            chk($sformatf("vec%0d_ready", k), req_ready, vt[k].e_ready);
            chk($sformatf("vec%0d_abort", k), abort, 0);
            if (vt[k].e_busy) chk($sformatf("vec%0d_din", k), fifo_din, vt[k].e_din);
        end

        // round-robin: all four valid with 2-beat bursts, requester 0 has a second burst
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            pq[i].push_back({1'b0, 8'(i*16)});
            pq[i].push_back({1'b1, 8'(i*16 + 1)});
        end
        pq[0].push_back({1'b0, 8'h02});
        pq[0].push_back({1'b1, 8'h03});
        exp_q = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
        eg_q  = '{0, 1, 2, 3, 0};
        eb_q  = '{2, 2, 2, 2, 2};
        run_until_done("rr", 100);
        chk("rr_aborts", n_abort, 0);

        // MAX_BURST cut: 12 beats from requester 1 split into 8 + 4
        do_reset();
        for (int b = 0; b < 12; b++) begin
            pq[1].push_back({(b == 11), 8'(8'h50 + b)});
            exp_q.push_back(8'(8'h50 + b));
        end
        eg_q = '{1, 1};
        eb_q = '{8, 4};
        run_until_done("maxb", 100);
        chk("maxb_aborts", n_abort, 0);

        // idle timeout: requester 2 sends one beat then goes quiet; requester 3 waits
        do_reset();
        pq[2].push_back({1'b0, 8'h60});
        pq[3].push_back({1'b0, 8'h70});
        pq[3].push_back({1'b1, 8'h71});
        exp_q = '{8'h60, 8'h70, 8'h71};
        eg_q  = '{2, 3};
        eb_q  = '{1, 2};
        run_until_done("tmo", 100);
        chk("tmo_aborts", n_abort, 1);
        chk("tmo_delay", t_abort - t_drop, IDLE_TO);

        // asynchronous reset during beat 3 of a requester 1 burst
        do_reset();
        for (int b = 0; b < 6; b++) begin
            pq[1].push_back({(b == 5), 8'(8'h80 + b)});
            exp_q.push_back(8'(8'h80 + b));
        end
        eg_q = '{1};
        hit  = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            bfm_sample();
            if (beat_cnt == 8'd2 && fifo_we) hit = 1'b1;
            else bfm_commit();
        end
        chk("arst_reach_beat3", hit, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_beat_cnt", beat_cnt, 0);
        chk("arst_fifo_we", fifo_we, 0);
        chk("arst_req_ready", req_ready, 0);
        do_reset();
        pq[0].push_back({1'b1, 8'h90});
        pq[1].push_back({1'b1, 8'h91});
        pq[3].push_back({1'b1, 8'h93});
        exp_q = '{8'h90, 8'h91, 8'h93};
        eg_q  = '{0, 1, 3};
        eb_q  = '{1, 1, 1};
        run_until_done("arst", 100);
        chk("arst_aborts", n_abort, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
